vga_board_scan: RTL and testbench
=================================

# vga_board_scan

VGA 640x480@60 timing generator and board-cell decoder that drives the board colour multiplexer directly. It produces the sync and blanking strobes and pixel coordinates. For every visible pixel it also produces a one-hot `pos` vector selecting which of the 50 board cells (10 columns x 5 rows) is being painted, plus a `line` flag for grid borders. All outputs are registered and mutually aligned, so the downstream mux output can go straight to the DAC.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel. Valid values are 1 or more; the default gives 25 MHz from 50 MHz.
- `BOARD_X0`, 120: first board pixel column.
- `BOARD_Y0`, 90: first board pixel row.
- `CELL_W`, 40: cell width in pixels.
- `CELL_H`, 60: cell height in pixels.
- `LINE_W`, 2: grid line thickness in pixels. Must be less than `CELL_W` and less than `CELL_H`.

Ports:
- `clk`  in  1  system clock. This is the block's only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `vga_clk`  out  1  pixel clock. 50% duty when `CLK_DIV` is even.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `blank_n`  out  1  high in the visible area.
- `sync_n`  out  1  tied high.
- `x`  out  10  current visible column. 0 when blanked.
- `y`  out  10  current visible row. 0 when blanked.
- `pos`  out  50  one-hot cell select. Bit k = row*10 + col; row 0 is the top row and col 0 is the leftmost column.
- `line`  out  1  grid border pixel.
- `frame_start`  out  1  one-`clk` pulse at the first pixel of each frame.

## Operation
- A divider counter generates the pixel tick `tick`: one `clk` high every `CLK_DIV` clocks. All other state advances only on `tick`.
- `hcnt` runs 0..799 and wraps to 0. When `hcnt` wraps, `vcnt` increments; `vcnt` runs 0..524 and wraps to 0.
- Visible area: `hcnt` < 640 and `vcnt` < 480.
- `hsync` is low for `hcnt` in 656..751. `vsync` is low for `vcnt` in 490..491.
- Board region: x in [BOARD_X0, BOARD_X0 + 10*CELL_W + LINE_W) and y in [BOARD_Y0, BOARD_Y0 + 5*CELL_H + LINE_W).
- Cell position is tracked with incremental counters; no divide or modulo operators are used.
  - The column counter `col` (0..9) and offset `xoff` (0..CELL_W-1) load 0 when `hcnt` = BOARD_X0.
  - `xoff` increments each tick. When it reaches CELL_W-1 it wraps and `col` increments.
  - Row counters `row` and `yoff` behave the same way, stepping once per line at `hcnt` = 799. They load 0 on the line where `vcnt` = BOARD_Y0.
- Per-pixel decode:
  - `line` = 1 when the pixel is inside the board region and any of these holds: `xoff` < LINE_W, `yoff` < LINE_W, x ≥ BOARD_X0 + 10*CELL_W, or y ≥ BOARD_Y0 + 5*CELL_H.
  - When `line` = 1, `pos` = 0.
  - Otherwise, inside the board, `pos` = 1 << (row*10 + col).
  - Outside the board or during blanking: `pos` = 0 and `line` = 0.
- Invariant: at most one bit of {`line`, `pos`} is set on any cycle.

## Timing
- Output stage: `hsync`, `vsync`, `blank_n`, `x`, `y`, `pos`, `line` are registered on `tick`. They reflect the counter values from the previous tick, so the pipeline latency is 1 pixel for all of them and they stay aligned.
- `frame_start` pulses high for exactly one `clk` on the tick whose outputs show `hcnt` = 0, `vcnt` = 0.
- Reset values:
  - divider, `hcnt`, `vcnt`, `col`, `row`, `xoff`, `yoff` = 0
  - `vga_clk` = 0
  - `hsync` = 1, `vsync` = 1
  - `blank_n` = 0, `x` = 0, `y` = 0, `pos` = 0, `line` = 0, `frame_start` = 0
- Reset asserted mid-frame: all state clears immediately and asynchronously. After release, the first tick outputs the pixel (0,0) with `frame_start` = 1.
- Frame period: 800*525 = 420000 ticks.

## Configuration
- `BOARD_GRID_LINES_EN` defined: `line` is decoded exactly as in Operation.
- `BOARD_GRID_LINES_EN` undefined:
  - `line` is tied 0.
  - Border pixels inside a cell decode to that cell's `pos` bit.
  - The trailing LINE_W-pixel strip at the right and bottom edges decodes to `pos` = 0.

## Structure
- Shared package `vga_pkg` holds:
  - the timing constants H_VIS=640, H_FP=16, H_SYNC=96, H_BP=48, V_VIS=480, V_FP=10, V_SYNC=2, V_BP=33;
  - `BOARD_COLS`=10 and `BOARD_ROWS`=5;
  - typedef `cell_sel_t` = logic [49:0].
- One sub-module, `vga_sync_counter`, contains the divider, `hcnt`/`vcnt` and the sync/visible decode. The cell decode and output registers stay in the top level.

## Test plan
- Reset, then run 420000 ticks: exactly one `frame_start` pulse per frame; `hsync` low for 96 ticks starting at `hcnt` 656; `vsync` low for 2 lines starting at `vcnt` 490.
- Pixel (120,90) → `line` = 1 and `pos` = 0. Pixel (150,100) → `pos`[0] = 1 and `line` = 0.
- Pixel (515,385) → `pos`[49] = 1. Pixel (520,200) → `line` = 1 (right border). Pixel (600,200) → `pos` = 0 and `line` = 0.
- Every cycle, assert `$onehot0({line,pos})`, and that `blank_n` = 0 implies `pos` = 0, `line` = 0, `x` = 0, `y` = 0.
- Assert `rst_n` at `hcnt` 300, `vcnt` 200 → all outputs at reset values within the same `clk`. After release, the first tick outputs (0,0) with `frame_start` = 1.
- Build without `BOARD_GRID_LINES_EN` → pixel (120,90) gives `pos`[0] = 1, and `line` is never 1 over a full frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, board geometry and cell-select helpers.
package vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 5;
  localparam int CELL_COUNT = BOARD_COLS * BOARD_ROWS;

  typedef logic [CELL_COUNT-1:0] cell_sel_t;

  // Caller guarantees row < BOARD_ROWS and col < BOARD_COLS.
  function automatic cell_sel_t cell_onehot(input logic [2:0] row, input logic [3:0] col);
    logic [5:0] idx;
    idx = 6'(row) * 6'(BOARD_COLS) + 6'(col);
    return cell_sel_t'(1) << idx;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-tick divider, horizontal/vertical counters and raw sync/visible decode.
// The next-count outputs let the parent keep its own counters aligned to hcnt/vcnt.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick,
  output logic       vga_clk,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic [9:0] hcnt_nxt,
  output logic [9:0] vcnt_nxt,
  output logic       h_wrap,
  output logic       visible,
  output logic       hsync_raw,
  output logic       vsync_raw
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic [9:0]       vcnt_q, vcnt_d;
  logic             vga_clk_q, vga_clk_d;

  always_comb begin
    tick  = (div_q == DIV_W'(CLK_DIV - 1));
    div_d = tick ? '0 : div_q + DIV_W'(1);
    // High in the second half of each pixel so the DAC samples mid-pixel.
    // With CLK_DIV = 1 this stays high; use clk itself as the pixel clock then.
    vga_clk_d = (div_d >= DIV_W'(CLK_DIV / 2));
  end

  always_comb begin
    h_wrap   = (hcnt_q == 10'(H_TOTAL - 1));
    hcnt_nxt = h_wrap ? '0 : hcnt_q + 10'd1;
    vcnt_nxt = vcnt_q;
    if (h_wrap) begin
      vcnt_nxt = (vcnt_q == 10'(V_TOTAL - 1)) ? '0 : vcnt_q + 10'd1;
    end
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      hcnt_d = hcnt_nxt;
      vcnt_d = vcnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      vga_clk_q <= vga_clk_d;
    end
  end

  assign hcnt    = hcnt_q;
  assign vcnt    = vcnt_q;
  assign vga_clk = vga_clk_q;

  assign visible   = (hcnt_q < 10'(H_VIS)) && (vcnt_q < 10'(V_VIS));
  assign hsync_raw = !((hcnt_q >= 10'(H_VIS + H_FP)) && (hcnt_q < 10'(H_VIS + H_FP + H_SYNC)));
  assign vsync_raw = !((vcnt_q >= 10'(V_VIS + V_FP)) && (vcnt_q < 10'(V_VIS + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_board_scan.sv
// VGA timing generator with registered board-cell decode (one-hot pos + grid line flag).
// Grid line decode is enabled by defining BOARD_GRID_LINES_EN; otherwise line is tied 0.
module vga_board_scan
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int BOARD_X0 = 120,
  parameter int BOARD_Y0 = 90,
  parameter int CELL_W   = 40,
  parameter int CELL_H   = 60,
  parameter int LINE_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            vga_clk,
  output logic            hsync,
  output logic            vsync,
  output logic            blank_n,
  output logic            sync_n,
  output logic [9:0]      x,
  output logic [9:0]      y,
  output logic [49:0]     pos,
  output logic            line,
  output logic            frame_start
);

  localparam int XOFF_W  = $clog2(CELL_W);
  localparam int YOFF_W  = $clog2(CELL_H);
  localparam int BX_EDGE = BOARD_X0 + BOARD_COLS * CELL_W;
  localparam int BY_EDGE = BOARD_Y0 + BOARD_ROWS * CELL_H;
  localparam int BX_END  = BX_EDGE + LINE_W;
  localparam int BY_END  = BY_EDGE + LINE_W;

  logic       tick, h_wrap, visible, hsync_raw, vsync_raw;
  logic [9:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;

  vga_sync_counter #(
    .CLK_DIV (CLK_DIV)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .vga_clk   (vga_clk),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .hcnt_nxt  (hcnt_nxt),
    .vcnt_nxt  (vcnt_nxt),
    .h_wrap    (h_wrap),
    .visible   (visible),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  logic [XOFF_W-1:0] xoff_q, xoff_d;
  logic [YOFF_W-1:0] yoff_q, yoff_d;
  logic [3:0]        col_q, col_d;
  logic [2:0]        row_q, row_d;

  // Cell counters track hcnt/vcnt; col/row saturate so the right/bottom
  // trailing strip never aliases back onto a real cell.
  always_comb begin
    xoff_d = xoff_q;
    col_d  = col_q;
    yoff_d = yoff_q;
    row_d  = row_q;
    if (tick) begin
      if (hcnt_nxt == 10'(BOARD_X0)) begin
        xoff_d = '0;
        col_d  = '0;
      end else if (xoff_q == XOFF_W'(CELL_W - 1)) begin
        xoff_d = '0;
        if (col_q != 4'hf) col_d = col_q + 4'd1;
      end else begin
        xoff_d = xoff_q + XOFF_W'(1);
      end
      if (h_wrap) begin
        if (vcnt_nxt == 10'(BOARD_Y0)) begin
          yoff_d = '0;
          row_d  = '0;
        end else if (yoff_q == YOFF_W'(CELL_H - 1)) begin
          yoff_d = '0;
          if (row_q != 3'h7) row_d = row_q + 3'd1;
        end else begin
          yoff_d = yoff_q + YOFF_W'(1);
        end
      end
    end
  end

  logic      in_board, edge_px, pix_line;
  cell_sel_t pix_pos;

  always_comb begin
    in_board = visible
            && (hcnt >= 10'(BOARD_X0)) && (hcnt < 10'(BX_END))
            && (vcnt >= 10'(BOARD_Y0)) && (vcnt < 10'(BY_END));
    edge_px  = (hcnt >= 10'(BX_EDGE)) || (vcnt >= 10'(BY_EDGE));
`ifdef BOARD_GRID_LINES_EN
    pix_line = in_board && ((xoff_q < XOFF_W'(LINE_W)) || (yoff_q < YOFF_W'(LINE_W)) || edge_px);
    pix_pos  = (in_board && !pix_line) ? cell_onehot(row_q, col_q) : '0;
`else
    pix_line = 1'b0;
    pix_pos  = (in_board && !edge_px) ? cell_onehot(row_q, col_q) : '0;
`endif
  end

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_n_q, blank_n_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  cell_sel_t  pos_q, pos_d;
  logic       line_q, line_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    blank_n_d = blank_n_q;
    x_d       = x_q;
    y_d       = y_q;
    pos_d     = pos_q;
    line_d    = line_q;
    if (tick) begin
      hsync_d   = hsync_raw;
      vsync_d   = vsync_raw;
      blank_n_d = visible;
      x_d       = visible ? hcnt : '0;
      y_d       = visible ? vcnt : '0;
      pos_d     = pix_pos;
      line_d    = pix_line;
    end
    frame_start_d = tick && (hcnt == '0) && (vcnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xoff_q        <= '0;
      yoff_q        <= '0;
      col_q         <= '0;
      row_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pos_q         <= '0;
      line_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      xoff_q        <= xoff_d;
      yoff_q        <= yoff_d;
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pos_q         <= pos_d;
      line_q        <= line_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign sync_n      = 1'b1;
  assign x           = x_q;
  assign y           = y_q;
  assign pos         = pos_q;
  assign line        = line_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_board_scan.sv
// Directed bench for vga_board_scan using a compressed board (Y0=2, CELL_H=4) so the
// whole board is scanned within the first 25 lines; expectations follow BOARD_GRID_LINES_EN.
module tb_vga_board_scan;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vga_clk, hsync, vsync, blank_n, sync_n, line_o, frame_start;
  logic [9:0]  x, y;
  logic [49:0] pos;

  int checks = 0;
  int failures = 0;
  int edges = 0;
  int fs_count = 0;
  int line_seen = 0;

  localparam logic [49:0] ONE = 50'd1;

  vga_board_scan #(
    .CLK_DIV  (CLK_DIV),
    .BOARD_X0 (120),
    .BOARD_Y0 (2),
    .CELL_W   (40),
    .CELL_H   (4),
    .LINE_W   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_clk     (vga_clk),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .sync_n      (sync_n),
    .x           (x),
    .y           (y),
    .pos         (pos),
    .line        (line_o),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the clk edge on which pixel (h,v) is presented, counted from reset release.
  task automatic goto(input int h, input int v);
    int target;
    target = CLK_DIV * (v * 800 + h + 1);
    checks++;
    assert (edges <= target) else begin
      failures++;
      $error("FAIL goto observed=%0d expected<=%0d", edges, target);
    end
    while (edges < target) begin
      @(posedge clk);
      edges++;
    end
    #1;
  endtask

  task automatic check_pixel(input string tag, input int h, input int v,
                             input logic [49:0] exp_pos, input logic exp_line);
    logic vis;
    goto(h, v);
    vis = (h < 640) && (v < 480);
    chk({tag, ".blank_n"}, 64'(blank_n), 64'(vis));
    chk({tag, ".x"}, 64'(x), vis ? 64'(h) : 64'd0);
    chk({tag, ".y"}, 64'(y), vis ? 64'(v) : 64'd0);
    chk({tag, ".hsync"}, 64'(hsync), 64'(!(h >= 656 && h < 752)));
    chk({tag, ".vsync"}, 64'(vsync), 64'(!(v >= 490 && v < 492)));
    chk({tag, ".pos"}, 64'(pos), 64'(exp_pos));
    chk({tag, ".line"}, 64'(line_o), 64'(exp_line));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".vga_clk"}, 64'(vga_clk), 64'd0);
    chk({tag, ".hsync"}, 64'(hsync), 64'd1);
    chk({tag, ".vsync"}, 64'(vsync), 64'd1);
    chk({tag, ".blank_n"}, 64'(blank_n), 64'd0);
    chk({tag, ".x"}, 64'(x), 64'd0);
    chk({tag, ".y"}, 64'(y), 64'd0);
    chk({tag, ".pos"}, 64'(pos), 64'd0);
    chk({tag, ".line"}, 64'(line_o), 64'd0);
    chk({tag, ".frame_start"}, 64'(frame_start), 64'd0);
  endtask

  always @(negedge clk) begin
    checks++;
    assert ($onehot0({line_o, pos})) else begin
      failures++;
      $error("FAIL onehot0 observed line=%0b pos=%0h expected at most one bit", line_o, pos);
    end
    if (!blank_n) begin
      checks++;
      assert (pos == '0 && !line_o && x == '0 && y == '0) else begin
        failures++;
        $error("FAIL blank_zero observed pos=%0h line=%0b x=%0d y=%0d expected all 0", pos, line_o, x, y);
      end
    end
    if (frame_start) fs_count++;
    if (line_o) line_seen = 1;
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    chk("sync_n", 64'(sync_n), 64'd1);

    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;

    goto(0, 0);
    chk("first.frame_start", 64'(frame_start), 64'd1);
    chk("first.x", 64'(x), 64'd0);
    chk("first.blank_n", 64'(blank_n), 64'd1);
    chk("first.vga_clk_lo", 64'(vga_clk), 64'd0);
    @(posedge clk);
    edges++;
    #1;
    chk("first.frame_start_drop", 64'(frame_start), 64'd0);
    chk("first.vga_clk_hi", 64'(vga_clk), 64'd1);

    check_pixel("h655", 655, 0, '0, 1'b0);
    check_pixel("h656", 656, 0, '0, 1'b0);
    check_pixel("h751", 751, 0, '0, 1'b0);
    check_pixel("h752", 752, 0, '0, 1'b0);

`ifdef BOARD_GRID_LINES_EN
    check_pixel("p120_2", 120, 2, '0, 1'b1);
    check_pixel("p150_4", 150, 4, ONE << 0, 1'b0);
    check_pixel("p130_7", 130, 7, '0, 1'b1);
    check_pixel("p119_10", 119, 10, '0, 1'b0);
    check_pixel("p520_10", 520, 10, '0, 1'b1);
    check_pixel("p600_10", 600, 10, '0, 1'b0);
    check_pixel("p700_10", 700, 10, '0, 1'b0);
    check_pixel("p250_16", 250, 16, ONE << 33, 1'b0);
    check_pixel("p515_21", 515, 21, ONE << 49, 1'b0);
    check_pixel("p300_23", 300, 23, '0, 1'b1);
    check_pixel("p300_24", 300, 24, '0, 1'b0);
`else
    check_pixel("p120_2", 120, 2, ONE << 0, 1'b0);
    check_pixel("p150_4", 150, 4, ONE << 0, 1'b0);
    check_pixel("p130_7", 130, 7, ONE << 10, 1'b0);
    check_pixel("p119_10", 119, 10, '0, 1'b0);
    check_pixel("p520_10", 520, 10, '0, 1'b0);
    check_pixel("p600_10", 600, 10, '0, 1'b0);
    check_pixel("p700_10", 700, 10, '0, 1'b0);
    check_pixel("p250_16", 250, 16, ONE << 33, 1'b0);
    check_pixel("p515_21", 515, 21, ONE << 49, 1'b0);
    check_pixel("p300_23", 300, 23, '0, 1'b0);
    check_pixel("p300_24", 300, 24, '0, 1'b0);
`endif

    check_pixel("pre_rst", 300, 25, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;

    goto(0, 0);
    chk("restart.frame_start", 64'(frame_start), 64'd1);
    chk("restart.blank_n", 64'(blank_n), 64'd1);
    chk("restart.x", 64'(x), 64'd0);
    chk("restart.y", 64'(y), 64'd0);
    check_pixel("restart_p150_4", 150, 4, ONE << 0, 1'b0);

    @(negedge clk);
    chk("frame_start_count", 64'(fs_count), 64'd2);
`ifdef BOARD_GRID_LINES_EN
    chk("line_seen", 64'(line_seen), 64'd1);
`else
    chk("line_seen", 64'(line_seen), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
